ika9958_cgen: RTL and testbench

//  Parametrised clock-enable generator; successor to the fixed 3-output DHCLK/DLCLK/CPUCLK divider in the rcc.

---
 rtl/ika9958_cgen.sv | 105 ++++++++++
 tb/tb_ika9958_cgen.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ika9958_cgen.sv
// Clock-enable generator: NCH divided clocks with runtime ratio/phase,
// edge strobes, external sync realignment and a sync watchdog.
module ika9958_cgen #(
    parameter int NCH   = 3,
    parameter int DIVW  = 4,
    parameter int LOCKW = 8
) (
    input  logic                i_XTAL1,
    input  logic                i_RST,
    input  logic                i_CEN,
    input  logic                i_SYNC_n,
    input  logic                i_SYNC_EN,
    input  logic [NCH*DIVW-1:0] i_DIV,
    input  logic [NCH*DIVW-1:0] i_PHASE,
    output logic [NCH-1:0]      o_CLK,
    output logic [NCH-1:0]      o_PCEN,
    output logic [NCH-1:0]      o_NCEN,
    output logic                o_LOCKED
);

    logic [NCH-1:0][DIVW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][DIVW-1:0] div_q, div_d;
    logic [NCH-1:0]           clk_q, clk_d;
    logic [NCH-1:0]           tc;
    logic [LOCKW-1:0]         wdog_q, wdog_d;
    logic                     locked_q, locked_d;
    logic                     sync_q;
    logic                     sync_fall;
    logic [DIVW-1:0]          dv;
    logic [DIVW-1:0]          ph;

    assign sync_fall = i_SYNC_EN & sync_q & ~i_SYNC_n;

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        clk_d = clk_q;
        tc    = '0;
        dv    = '0;
        ph    = '0;
        for (int k = 0; k < NCH; k++) begin
            dv    = i_DIV[k*DIVW +: DIVW];
            ph    = i_PHASE[k*DIVW +: DIVW];
            tc[k] = (cnt_q[k] == div_q[k]);
            if (sync_fall) begin
                // Phase beyond the ratio would overshoot terminal count.
                cnt_d[k] = (ph > dv) ? dv : ph;
                clk_d[k] = 1'b0;
                div_d[k] = dv;
            end else if (i_CEN) begin
                if (tc[k]) begin
                    cnt_d[k] = '0;
                    clk_d[k] = ~clk_q[k];
                    div_d[k] = dv;
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        wdog_d   = wdog_q;
        locked_d = locked_q;
        if (!i_SYNC_EN) begin
            wdog_d   = '0;
            locked_d = 1'b0;
        end else if (sync_fall) begin
            wdog_d   = '0;
            locked_d = 1'b1;
        end else if (i_CEN) begin
            if (wdog_q != '1) begin
                wdog_d = wdog_q + 1'b1;
            end
            if (wdog_d == '1) begin
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_XTAL1) begin
        if (i_RST) begin
            cnt_q    <= '0;
            clk_q    <= '0;
            div_q    <= i_DIV;
            sync_q   <= 1'b1;
            wdog_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            div_q    <= div_d;
            sync_q   <= i_SYNC_n;
            wdog_q   <= wdog_d;
            locked_q <= locked_d;
        end
    end

    // A sync-forced drop still reports a falling edge; a pending rise is cancelled.
    assign o_PCEN   = {NCH{i_CEN & ~i_RST & ~sync_fall}} & ~clk_q & tc;
    assign o_NCEN   = {NCH{i_CEN & ~i_RST}} & clk_q & (tc | {NCH{sync_fall}});
    assign o_CLK    = clk_q;
    assign o_LOCKED = locked_q;

endmodule

// File: tb/tb_ika9958_cgen.sv
// Self-checking bench for ika9958_cgen: closed-form expectations
// queued per cycle and compared against the DUT outputs.
module tb_ika9958_cgen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        sync_n;
    logic        sync_en;
    logic [11:0] div;
    logic [11:0] phase;
    logic [2:0]  o_clk;
    logic [2:0]  o_pcen;
    logic [2:0]  o_ncen;
    logic        o_locked;

    int errors = 0;
    int checks = 0;

    // v = {clk[2:0], pcen[2:0], ncen[2:0], locked}
    typedef struct packed {
        logic [9:0] v;
        logic [9:0] m;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    ika9958_cgen #(.NCH(3), .DIVW(4), .LOCKW(4)) dut (
        .i_XTAL1  (clk),
        .i_RST    (rst),
        .i_CEN    (cen),
        .i_SYNC_n (sync_n),
        .i_SYNC_EN(sync_en),
        .i_DIV    (div),
        .i_PHASE  (phase),
        .o_CLK    (o_clk),
        .o_PCEN   (o_pcen),
        .o_NCEN   (o_ncen),
        .o_LOCKED (o_locked)
    );

    function automatic logic [11:0] pack3(int a, int b, int c);
        return {4'(c), 4'(b), 4'(a)};
    endfunction

    // Level of a free-running divided clock after t ticks, half-period h+1.
    function automatic logic clk_at(int t, int h);
        return ((t / (h + 1)) % 2) == 1;
    endfunction

    // Ch0 level when the ratio changes from 1 to 3 during the first half-period.
    function automatic logic rc_clk(int n);
        if (n < 2) return 1'b0;
        return (((n - 2) / 4) % 2) == 0;
    endfunction

    function automatic logic [9:0] observe();
        return {o_clk, o_pcen, o_ncen, o_locked};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t g;
        logic [9:0] obs;
        div     = pack3(1, 2, 3);
        phase   = '0;
        cen     = 1'b1;
        sync_en = 1'b1;
        sync_n  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        e.v = '0;
        e.m = 10'b000_111_111_0;
        sbq.push_back(e);
        #1;
        g   = sbq.pop_front();
        obs = observe();
        checks++;
        if ((obs & g.m) !== (g.v & g.m)) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=%b", obs & g.m, g.v);
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            e.v = '0;
            e.m = '1;
            sbq.push_back(e);
            #1;
            g   = sbq.pop_front();
            obs = observe();
            checks++;
            if ((obs & g.m) !== (g.v & g.m)) begin
                errors++;
                $display("FAIL reset_state n=%0d got=%b exp=%b", n, obs, g.v);
            end
        end
    endtask

    task automatic test_free_run();
        exp_t e;
        exp_t g;
        logic [9:0] obs;
        logic c;
        logic c1;
        div     = pack3(0, 1, 2);
        phase   = '0;
        sync_en = 1'b0;
        sync_n  = 1'b1;
        cen     = 1'b1;
        apply_reset();
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            rst = 1'b0;
            e.v = '0;
            e.m = '1;
            for (int k = 0; k < 3; k++) begin
                c          = clk_at(n, k);
                c1         = clk_at(n + 1, k);
                e.v[7 + k] = c;
                e.v[4 + k] = ~c & c1;
                e.v[1 + k] = c & ~c1;
            end
            sbq.push_back(e);
            #1;
            g   = sbq.pop_front();
            obs = observe();
            checks++;
            if ((obs & g.m) !== (g.v & g.m)) begin
                errors++;
                $display("FAIL free_run n=%0d got=%b exp=%b", n, obs, g.v);
            end
        end
    endtask

    task automatic test_cen_half();
        exp_t e;
        exp_t g;
        logic [9:0] obs;
        logic c;
        logic c1;
        int t;
        div     = pack3(1, 1, 1);
        phase   = '0;
        sync_en = 1'b0;
        sync_n  = 1'b1;
        cen     = 1'b1;
        apply_reset();
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            rst = 1'b0;
            cen = (n % 2) == 1;
            t   = n / 2;
            c   = clk_at(t, 1);
            c1  = clk_at(t + 1, 1);
            e.v = {{3{c}}, {3{cen & ~c & c1}}, {3{cen & c & ~c1}}, 1'b0};
            e.m = '1;
            sbq.push_back(e);
            #1;
            g   = sbq.pop_front();
            obs = observe();
            checks++;
            if ((obs & g.m) !== (g.v & g.m)) begin
                errors++;
                $display("FAIL cen_half n=%0d got=%b exp=%b", n, obs, g.v);
            end
        end
    endtask

    task automatic test_ratio_change();
        exp_t e;
        exp_t g;
        logic [9:0] obs;
        logic c;
        logic c1;
        div     = pack3(1, 0, 0);
        phase   = '0;
        sync_en = 1'b0;
        sync_n  = 1'b1;
        cen     = 1'b1;
        apply_reset();
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            rst = 1'b0;
            div = pack3(3, 0, 0);
            c   = rc_clk(n);
            c1  = rc_clk(n + 1);
            e.v = '0;
            e.v[7] = c;
            e.v[4] = ~c & c1;
            e.v[1] = c & ~c1;
            e.m = 10'b001_001_001_0;
            sbq.push_back(e);
            #1;
            g   = sbq.pop_front();
            obs = observe();
            checks++;
            if ((obs & g.m) !== (g.v & g.m)) begin
                errors++;
                $display("FAIL ratio_change n=%0d got=%b exp=%b", n, obs & g.m, g.v);
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        exp_t g;
        logic [9:0] obs;
        logic c;
        logic c1;
        int h[3];
        h[0] = 3;
        h[1] = 5;
        h[2] = 0;
        div     = pack3(3, 5, 0);
        phase   = pack3(2, 15, 0);
        sync_en = 1'b1;
        sync_n  = 1'b1;
        cen     = 1'b1;
        apply_reset();
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            rst    = 1'b0;
            sync_n = (n >= 5) ? 1'b0 : 1'b1;
            e.v = '0;
            e.m = '1;
            case (n)
                5: e.v = 10'b101_000_101_0;
                6: e.v = 10'b000_110_000_1;
                7: e.v = 10'b110_001_100_1;
                8: e.v = 10'b011_100_000_1;
                default: begin
                    for (int k = 0; k < 3; k++) begin
                        c          = clk_at(n, h[k]);
                        c1         = clk_at(n + 1, h[k]);
                        e.v[7 + k] = c;
                        e.v[4 + k] = ~c & c1;
                        e.v[1 + k] = c & ~c1;
                    end
                end
            endcase
            sbq.push_back(e);
            #1;
            g   = sbq.pop_front();
            obs = observe();
            checks++;
            if ((obs & g.m) !== (g.v & g.m)) begin
                errors++;
                $display("FAIL sync n=%0d got=%b exp=%b", n, obs, g.v);
            end
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        exp_t g;
        logic [9:0] obs;
        div     = pack3(0, 0, 0);
        phase   = '0;
        sync_en = 1'b1;
        sync_n  = 1'b1;
        cen     = 1'b1;
        apply_reset();
        for (int n = 0; n < 28; n++) begin
            @(negedge clk);
            rst     = 1'b0;
            sync_n  = (n >= 2 && n != 23) ? 1'b0 : 1'b1;
            sync_en = n < 26;
            e.v = '0;
            e.v[0] = (n >= 3 && n <= 17) || n == 25 || n == 26;
            e.m = 10'b000_000_000_1;
            sbq.push_back(e);
            #1;
            g   = sbq.pop_front();
            obs = observe();
            checks++;
            if ((obs & g.m) !== (g.v & g.m)) begin
                errors++;
                $display("FAIL watchdog n=%0d got=%b exp=%b", n, o_locked, g.v[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t g;
        logic [9:0] obs;
        logic [9:0] tbl[7];
        tbl[2] = 10'b000_111_000_1;
        tbl[3] = 10'b111_000_000_1;
        tbl[4] = 10'b000_000_000_0;
        tbl[5] = 10'b000_111_000_1;
        tbl[6] = 10'b111_000_110_1;
        div     = pack3(5, 0, 0);
        phase   = pack3(15, 0, 0);
        sync_en = 1'b1;
        sync_n  = 1'b1;
        cen     = 1'b1;
        apply_reset();
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            sync_n = (n >= 1) ? 1'b0 : 1'b1;
            rst    = (n == 3);
            cen    = !(n == 3 || n == 4);
            if (n >= 2) begin
                e.v = tbl[n];
                e.m = '1;
                sbq.push_back(e);
                #1;
                g   = sbq.pop_front();
                obs = observe();
                checks++;
                if ((obs & g.m) !== (g.v & g.m)) begin
                    errors++;
                    $display("FAIL reset_mid n=%0d got=%b exp=%b", n, obs, g.v);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        cen     = 1'b0;
        sync_n  = 1'b1;
        sync_en = 1'b0;
        div     = '0;
        phase   = '0;
        test_reset();
        test_free_run();
        test_cen_half();
        test_ratio_change();
        test_sync();
        test_watchdog();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
